aritmetik_cok_dongulu: RTL
==========================

Name: aritmetik_cok_dongulu

Overview:
Parametrised arithmetic unit for the islemci datapath.
- Decodes emir_i[2:0] and supports add, subtract, multiply and an optional divide.
- Takes operands through a gecerli_i/hazir_o handshake.
- Add and subtract complete in a single cycle. Multiply (shift-add) and divide (restoring) are iterative, one bit per cycle.
- Each result is announced with a one-cycle veriyi_yaz_o pulse toward the register file.

Parameters:
VERI_GENISLIK, 8, operand and result width W (must be ≥2).
EMIR_GENISLIK, 16, instruction word width; only bits [2:0] are decoded.

Ports:
clk  input  1  clock; all logic runs on the rising edge.
rst  input  1  asynchronous, active-low reset.
gecerli_i  input  1  operands and emir_i are valid this cycle.
hazir_o  output  1  unit can accept a new operation.
emir_i  input  EMIR_GENISLIK  instruction word; [2:0] is the opcode.
veri1_i  input  W  first operand (dividend).
veri2_i  input  W  second operand (divisor).
sonuc_o  output  W  result: low half of a product, or the quotient.
sonuc_ust_o  output  W  high half of a product, or the remainder; 0 for add/sub.
elde_o  output  1  carry-out (add) or borrow (sub); 0 for mul/div.
sifir_o  output  1  selected result is zero.
gecersiz_o  output  1  one-cycle pulse: illegal opcode or divide-by-zero.
veriyi_yaz_o  output  1  one-cycle pulse: sonuc_o and flags are valid and must be written.

Behaviour:
- Reset: while rst=0, asynchronously force state BOS. sonuc_o, sonuc_ust_o, elde_o, sifir_o, gecersiz_o and veriyi_yaz_o all go to 0. Iteration counter goes to 0. gecerli_i is ignored while in reset.
- hazir_o = 1 exactly when state == BOS.
- Accept: an operation is accepted on a rising edge where gecerli_i=1 and hazir_o=1. Operands and opcode are captured on that edge.
- Opcodes:
  - 000 add: sonuc_o = (veri1+veri2) mod 2^W; elde_o = carry.
  - 010 sub: sonuc_o = (veri1−veri2) mod 2^W; elde_o = 1 when veri1 < veri2.
  - 100 mul: unsigned; {sonuc_ust_o, sonuc_o} = 2W-bit product.
  - 110 div: only when the optional feature is enabled.
  - Every other code is illegal.
- States:
  - BOS: idle.
  - CARP: W iterations, one partial-product bit per cycle.
  - BOL: W iterations, one restoring-division step per cycle.
- Transitions:
  - BOS→CARP on an accepted mul; BOS→BOL on an accepted div.
  - CARP/BOL→BOS when the counter reaches W−1.
  - add/sub/illegal stay in BOS.
- Latency:
  - add/sub: results and veriyi_yaz_o=1 appear on the accept edge. hazir_o stays 1, so back-to-back accepts are allowed every cycle.
  - mul/div: results and veriyi_yaz_o=1 appear W edges after the accept edge. hazir_o=0 for exactly W cycles.
- Illegal opcode: gecersiz_o=1 for one cycle at the accept edge. veriyi_yaz_o stays 0 and result outputs keep their previous values.
- Output timing:
  - veriyi_yaz_o and gecersiz_o are never high for more than one cycle per operation.
  - Result outputs hold their values until the next completing operation.
- sifir_o source:
  - add/sub: sonuc_o == 0.
  - mul: the full 2W-bit product == 0.
  - div: the quotient == 0.
- Flag updates: elde_o and sifir_o update only together with veriyi_yaz_o.
- gecerli_i while hazir_o=0 is ignored, not queued. Upstream must hold the request until it is accepted.
- Reset during CARP/BOL aborts the operation. No veriyi_yaz_o pulse is produced and the unit resumes in BOS.
- Operand changes during an iteration have no effect, because captured copies are used.

Optional Feature:
Macro ARITMETIK_BOLME_EN.
- Defined:
  - Opcode 110 performs unsigned restoring division: sonuc_o = quotient, sonuc_ust_o = remainder, latency W.
  - Divisor 0: still runs W cycles, then sonuc_o = all ones, sonuc_ust_o = veri1, veriyi_yaz_o=1 and gecersiz_o=1 in the same cycle.
- Undefined:
  - The BOL state and divider logic are not synthesised.
  - 110 is handled as an illegal opcode.

Test Plan:
1. Add with W=8: 200 + 100 → same edge: sonuc_o=0x2C, elde_o=1, sifir_o=0, veriyi_yaz_o=1 for 1 cycle. hazir_o stays 1.
2. Sub 5 − 7, then sub 9 − 9 on consecutive cycles → first result 0xFE with elde_o=1, next cycle 0x00 with sifir_o=1 and elde_o=0.
3. Mul 200 × 3 → hazir_o=0 for 8 cycles. Then sonuc_o=0x58, sonuc_ust_o=0x02, veriyi_yaz_o pulses once. A gecerli_i asserted mid-operation is ignored.
4. With ARITMETIK_BOLME_EN defined:
   - 100 ÷ 7 → after 8 cycles sonuc_o=14, sonuc_ust_o=2.
   - 100 ÷ 0 → sonuc_o=0xFF, sonuc_ust_o=100, gecersiz_o=1.
   - Without the macro, 110 → gecersiz_o only.
5. Opcode 001 → gecersiz_o pulses, veriyi_yaz_o=0, previous sonuc_o is retained.
6. rst=0 asserted 3 cycles into a mul → outputs go to 0 immediately. After release, hazir_o=1 and no veriyi_yaz_o pulse appears. A following add 1 + 1 gives sonuc_o=2.

Source files
------------

// File: rtl/aritmetik_cok_dongulu.sv
// Multi-cycle arithmetic unit: add/sub in one cycle, shift-add mul over W cycles.
// Restoring divide (opcode 110) is built only when ARITMETIK_BOLME_EN is defined.
`timescale 1ns/1ps
module aritmetik_cok_dongulu #(
  parameter int VERI_GENISLIK = 8,
  parameter int EMIR_GENISLIK = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gecerli_i,
  output logic                     hazir_o,
  input  logic [EMIR_GENISLIK-1:0] emir_i,
  input  logic [VERI_GENISLIK-1:0] veri1_i,
  input  logic [VERI_GENISLIK-1:0] veri2_i,
  output logic [VERI_GENISLIK-1:0] sonuc_o,
  output logic [VERI_GENISLIK-1:0] sonuc_ust_o,
  output logic                     elde_o,
  output logic                     sifir_o,
  output logic                     gecersiz_o,
  output logic                     veriyi_yaz_o
);

  localparam int W  = VERI_GENISLIK;
  localparam int SW = (W > 2) ? $clog2(W) : 1;

  localparam logic [2:0] OP_TOPLA = 3'b000;
  localparam logic [2:0] OP_CIKAR = 3'b010;
  localparam logic [2:0] OP_CARP  = 3'b100;
`ifdef ARITMETIK_BOLME_EN
  localparam logic [2:0] OP_BOL   = 3'b110;
`endif

`ifdef ARITMETIK_BOLME_EN
  typedef enum logic [1:0] {BOS, CARP, BOL} durum_t;
`else
  typedef enum logic [1:0] {BOS, CARP} durum_t;
`endif

  durum_t durum_q, durum_d;

  logic [SW-1:0] sayac_q, sayac_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  ust_q, ust_d;
  logic [W-1:0]  alt_q, alt_d;

  logic [W-1:0] sonuc_q, sonuc_d;
  logic [W-1:0] sonuc_ust_q, sonuc_ust_d;
  logic         elde_q, elde_d;
  logic         sifir_q, sifir_d;
  logic         gecersiz_q, gecersiz_d;
  logic         yaz_q, yaz_d;

  logic [2:0] op;
  logic       is_topla, is_cikar, is_carp;
  logic       kabul, son_adim;

  logic [W:0]   toplam, fark;
  logic [W:0]   carp_top;
  logic [W-1:0] carp_ust_n, carp_alt_n;

  logic unused_emir;

  assign unused_emir = ^emir_i[EMIR_GENISLIK-1:3];

  assign op       = emir_i[2:0];
  assign is_topla = (op == OP_TOPLA);
  assign is_cikar = (op == OP_CIKAR);
  assign is_carp  = (op == OP_CARP);

  assign hazir_o  = (durum_q == BOS);
  assign kabul    = gecerli_i && hazir_o;
  assign son_adim = (sayac_q == SW'(W - 1));

  assign toplam = {1'b0, veri1_i} + {1'b0, veri2_i};
  assign fark   = {1'b0, veri1_i} - {1'b0, veri2_i};

  // Accumulator {ust,alt}: alt starts as the multiplier and shifts out LSB-first.
  assign carp_top   = {1'b0, ust_q} + (alt_q[0] ? {1'b0, a_q} : '0);
  assign carp_ust_n = carp_top[W:1];
  assign carp_alt_n = {carp_top[0], alt_q[W-1:1]};

`ifdef ARITMETIK_BOLME_EN
  logic         is_bol;
  logic [W:0]   bol_kay, bol_fark;
  logic         bol_ok;
  logic [W-1:0] bol_kalan_n, bol_bolum_n;

  assign is_bol = (op == OP_BOL);

  // ust holds the partial remainder, alt the dividend turning into the quotient.
  // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
  assign bol_kay     = {ust_q, alt_q[W-1]};
  assign bol_fark    = bol_kay - {1'b0, a_q};
  assign bol_ok      = !bol_fark[W];
  assign bol_kalan_n = bol_ok ? bol_fark[W-1:0] : bol_kay[W-1:0];
  assign bol_bolum_n = {alt_q[W-2:0], bol_ok};
`endif

  always_comb begin
    durum_d     = durum_q;
    sayac_d     = sayac_q;
    a_d         = a_q;
    ust_d       = ust_q;
    alt_d       = alt_q;
    sonuc_d     = sonuc_q;
    sonuc_ust_d = sonuc_ust_q;
    elde_d      = elde_q;
    sifir_d     = sifir_q;
    gecersiz_d  = 1'b0;
    yaz_d       = 1'b0;

    unique case (durum_q)
      BOS: begin
        if (kabul) begin
          unique case (1'b1)
            is_topla: begin
              sonuc_d     = toplam[W-1:0];
              sonuc_ust_d = '0;
              elde_d      = toplam[W];
              sifir_d     = (toplam[W-1:0] == '0);
              yaz_d       = 1'b1;
            end
            is_cikar: begin
              sonuc_d     = fark[W-1:0];
              sonuc_ust_d = '0;
              elde_d      = fark[W];
              sifir_d     = (fark[W-1:0] == '0);
              yaz_d       = 1'b1;
            end
            is_carp: begin
              a_d     = veri1_i;
              ust_d   = '0;
              alt_d   = veri2_i;
              sayac_d = '0;
              durum_d = CARP;
            end
`ifdef ARITMETIK_BOLME_EN
            is_bol: begin
              a_d     = veri2_i;
              ust_d   = '0;
              alt_d   = veri1_i;
              sayac_d = '0;
              durum_d = BOL;
            end
`endif
            default: gecersiz_d = 1'b1;
          endcase
        end
      end
      CARP: begin
        ust_d   = carp_ust_n;
        alt_d   = carp_alt_n;
        sayac_d = sayac_q + SW'(1);
        if (son_adim) begin
          sayac_d     = '0;
          durum_d     = BOS;
          sonuc_d     = carp_alt_n;
          sonuc_ust_d = carp_ust_n;
          elde_d      = 1'b0;
          sifir_d     = ({carp_ust_n, carp_alt_n} == '0);
          yaz_d       = 1'b1;
        end
      end
`ifdef ARITMETIK_BOLME_EN
      BOL: begin
        ust_d   = bol_kalan_n;
        alt_d   = bol_bolum_n;
        sayac_d = sayac_q + SW'(1);
        if (son_adim) begin
          sayac_d     = '0;
          durum_d     = BOS;
          sonuc_d     = bol_bolum_n;
          sonuc_ust_d = bol_kalan_n;
          elde_d      = 1'b0;
          sifir_d     = (bol_bolum_n == '0);
          gecersiz_d  = (a_q == '0);
          yaz_d       = 1'b1;
        end
      end
`endif
      default: begin
        durum_d = BOS;
        sayac_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum_q     <= BOS;
      sayac_q     <= '0;
      a_q         <= '0;
      ust_q       <= '0;
      alt_q       <= '0;
      sonuc_q     <= '0;
      sonuc_ust_q <= '0;
      elde_q      <= 1'b0;
      sifir_q     <= 1'b0;
      gecersiz_q  <= 1'b0;
      yaz_q       <= 1'b0;
    end else begin
      durum_q     <= durum_d;
      sayac_q     <= sayac_d;
      a_q         <= a_d;
      ust_q       <= ust_d;
      alt_q       <= alt_d;
      sonuc_q     <= sonuc_d;
      sonuc_ust_q <= sonuc_ust_d;
      elde_q      <= elde_d;
      sifir_q     <= sifir_d;
      gecersiz_q  <= gecersiz_d;
      yaz_q       <= yaz_d;
    end
  end

  assign sonuc_o      = sonuc_q;
  assign sonuc_ust_o  = sonuc_ust_q;
  assign elde_o       = elde_q;
  assign sifir_o      = sifir_q;
  assign gecersiz_o   = gecersiz_q;
  assign veriyi_yaz_o = yaz_q;

endmodule
